// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, channel state type and divisor clamp for clk_div_prog
package clk_div_pkg;

    localparam int CLK_DIV_CNT_W_DEF = 20;
    localparam int CLK_DIV_MIN       = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } chan_state_t;

    // A zero divisor would never reach a boundary, so it is promoted to the minimum.
    function automatic logic [31:0] clamp_div(input logic [31:0] i_val);
        return (i_val == 32'd0) ? 32'(CLK_DIV_MIN) : i_val;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: half-period counter, shadow divisor and IDLE/RUN/DRAIN FSM
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CLK_DIV_CNT_W_DEF,
    parameter int DEFAULT_DIV = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_align,
    input  logic [CNT_W-1:0] i_div_in,
    input  logic             i_div_load,
    output logic             o_div_pending,
    output logic             o_out_clk,
    output logic             o_tick
);

    chan_state_t      r_state;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_div_new;
    logic             w_bound;

    assign w_div_new = CNT_W'(clamp_div(32'(i_div_in)));
    assign w_bound   = (r_cycle == r_div_act - CNT_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cycle   <= '0;
            r_div_act <= CNT_W'(DEFAULT_DIV);
            r_shadow  <= CNT_W'(DEFAULT_DIV);
            r_pending <= 1'b0;
            r_out     <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_align) begin
            r_cycle <= '0;
            r_out   <= 1'b0;
            r_tick  <= 1'b0;
            r_state <= i_enable ? RUN : IDLE;
            if (r_pending) begin
                r_div_act <= r_shadow;
            end
            if (i_div_load) begin
                r_shadow  <= w_div_new;
                r_pending <= 1'b1;
            end else begin
                r_pending <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
            if (i_div_load) begin
                r_shadow  <= w_div_new;
                r_pending <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_cycle <= '0;
                    r_out   <= 1'b0;
                    if (i_div_load) begin
                        r_div_act <= w_div_new;
                        r_pending <= 1'b0;
                    end else if (r_pending) begin
                        r_div_act <= r_shadow;
                        r_pending <= 1'b0;
                    end
                    if (i_enable) begin
                        r_state <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (!i_enable && !r_out) begin
                        r_state <= IDLE;
                        r_cycle <= '0;
                    end else if (w_bound) begin
                        r_cycle <= '0;
                        r_out   <= ~r_out;
                        r_tick  <= 1'b1;
                        if (r_pending) begin
                            r_div_act <= r_shadow;
                            if (!i_div_load) begin
                                r_pending <= 1'b0;
                            end
                        end
                        // Disabled here means the high phase is ending, so the channel parks low.
                        r_state <= i_enable ? RUN : IDLE;
                    end else begin
                        r_cycle <= r_cycle + CNT_W'(1);
                        r_state <= i_enable ? RUN : DRAIN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_div_pending = r_pending;
    assign o_out_clk     = r_out;
    assign o_tick        = r_tick;

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - multi-channel programmable clock divider top; CLK_DIV_PHASE_ALIGN_EN adds the align input
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CLK_DIV_CNT_W_DEF,
    parameter int DEFAULT_DIV = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       div_load,
`ifdef CLK_DIV_PHASE_ALIGN_EN
    input  logic                    align,
`endif
    output logic [NUM_CH-1:0]       div_pending,
    output logic [NUM_CH-1:0]       out_clk,
    output logic [NUM_CH-1:0]       tick
);

    logic [1:0] r_rst_sync;
    logic       w_rst;
    logic       w_align;

    // Reset asserts immediately but releases only after two clean clk edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

`ifdef CLK_DIV_PHASE_ALIGN_EN
    assign w_align = align;
`else
    assign w_align = 1'b0;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .i_clk         (clk),
            .i_rst         (w_rst),
            .i_enable      (enable[k]),
            .i_align       (w_align),
            .i_div_in      (div_in[k*CNT_W +: CNT_W]),
            .i_div_load    (div_load[k]),
            .o_div_pending (div_pending[k]),
            .o_out_clk     (out_clk[k]),
            .o_tick        (tick[k])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 20;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*CNT_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       div_pending;
    logic [NUM_CH-1:0]       out_clk;
    logic [NUM_CH-1:0]       tick;
`ifdef CLK_DIV_PHASE_ALIGN_EN
    logic                    align;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clk_div_prog #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .div_in      (div_in),
        .div_load    (div_load),
`ifdef CLK_DIV_PHASE_ALIGN_EN
        .align       (align),
`endif
        .div_pending (div_pending),
        .out_clk     (out_clk),
        .tick        (tick)
    );

    // Counts falling edges until out_clk[ch] changes; -1 when the bound expires.
    task automatic wait_toggle(input int ch, output int n);
        logic v;
        v = out_clk[ch];
        n = 0;
        while (out_clk[ch] === v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (out_clk[ch] === v) n = -1;
    endtask

    task automatic load_div(input int ch, input int val);
        div_in[ch*CNT_W +: CNT_W] = CNT_W'(val);
        div_load[ch] = 1'b1;
        @(negedge clk);
        div_load = '0;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        enable   = '0;
        div_load = '0;
        div_in   = '0;
`ifdef CLK_DIV_PHASE_ALIGN_EN
        align    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_cmp++; if (out_clk !== 2'b00) begin n_bad++; $display("FAIL reset_out_clk: got %b expected 00", out_clk); end
        n_cmp++; if (tick !== 2'b00) begin n_bad++; $display("FAIL reset_tick: got %b expected 00", tick); end
        n_cmp++; if (div_pending !== 2'b00) begin n_bad++; $display("FAIL reset_pending: got %b expected 00", div_pending); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_default;
        int n;
        enable = 2'b11;
        wait_toggle(0, n);
        n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL default_first_rise: got %0d expected 17", n); end
        n_cmp++; if (out_clk !== 2'b11) begin n_bad++; $display("FAIL default_both_high: got %b expected 11", out_clk); end
        n_cmp++; if (tick !== 2'b11) begin n_bad++; $display("FAIL default_tick_on_toggle: got %b expected 11", tick); end
        wait_toggle(0, n);
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL default_high_phase: got %0d expected 16", n); end
        n_cmp++; if (out_clk !== 2'b00) begin n_bad++; $display("FAIL default_both_low: got %b expected 00", out_clk); end
        wait_toggle(0, n);
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL default_low_phase: got %0d expected 16", n); end
        @(negedge clk);
        n_cmp++; if (tick !== 2'b00) begin n_bad++; $display("FAIL default_tick_one_cycle: got %b expected 00", tick); end
    endtask

    task automatic test_reload;
        int n;
        repeat (4) @(negedge clk);
        load_div(0, 4);
        n_cmp++; if (div_pending !== 2'b01) begin n_bad++; $display("FAIL reload_pending_set: got %b expected 01", div_pending); end
        wait_toggle(0, n);
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL reload_old_half_finishes: got %0d expected 10", n); end
        n_cmp++; if (div_pending !== 2'b00) begin n_bad++; $display("FAIL reload_pending_clear: got %b expected 00", div_pending); end
        wait_toggle(0, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL reload_new_high: got %0d expected 4", n); end
        wait_toggle(0, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL reload_new_low: got %0d expected 4", n); end
    endtask

    task automatic test_collision;
        int n;
        load_div(0, 12);
        wait_toggle(0, n);
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL collision_setup_half: got %0d expected 3", n); end
        repeat (2) @(negedge clk);
        load_div(0, 4);
        repeat (8) @(negedge clk);
        load_div(0, 8);
        n_cmp++; if (out_clk[0] !== 1'b0 || tick[0] !== 1'b1) begin n_bad++; $display("FAIL collision_toggle_on_load: got out=%b tick=%b expected out=0 tick=1", out_clk[0], tick[0]); end
        n_cmp++; if (div_pending[0] !== 1'b1) begin n_bad++; $display("FAIL collision_new_pending: got %b expected 1", div_pending[0]); end
        wait_toggle(0, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL collision_old_shadow_half: got %0d expected 4", n); end
        n_cmp++; if (div_pending[0] !== 1'b0) begin n_bad++; $display("FAIL collision_pending_clear: got %b expected 0", div_pending[0]); end
        wait_toggle(0, n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL collision_new_half: got %0d expected 8", n); end
    endtask

    task automatic test_disable;
        int n;
        logic bad;
        load_div(0, 16);
        wait_toggle(0, n);
        n_cmp++; if (n !== 7 || out_clk[0] !== 1'b1) begin n_bad++; $display("FAIL disable_rise: got n=%0d out=%b expected n=7 out=1", n, out_clk[0]); end
        repeat (2) @(negedge clk);
        enable[0] = 1'b0;
        wait_toggle(0, n);
        n_cmp++; if (n !== 14) begin n_bad++; $display("FAIL disable_drain_len: got %0d expected 14", n); end
        n_cmp++; if (out_clk[0] !== 1'b0 || tick[0] !== 1'b1) begin n_bad++; $display("FAIL disable_fall: got out=%b tick=%b expected out=0 tick=1", out_clk[0], tick[0]); end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_clk[0] !== 1'b0 || tick[0] !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL disable_stays_idle: got activity=%b expected 0", bad); end
        wait_toggle(1, n);
        wait_toggle(1, n);
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL disable_ch1_unaffected: got %0d expected 16", n); end
    endtask

    task automatic test_zero_min;
        int n;
        load_div(0, 0);
        n_cmp++; if (div_pending[0] !== 1'b0) begin n_bad++; $display("FAIL zero_idle_load_direct: got %b expected 0", div_pending[0]); end
        enable[0] = 1'b1;
        wait_toggle(0, n);
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL zero_first_toggle: got %0d expected 2", n); end
        wait_toggle(0, n);
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL zero_half: got %0d expected 1", n); end
        load_div(0, 1);
        wait_toggle(0, n);
        wait_toggle(0, n);
        n_cmp++; if (n !== 1 || tick[0] !== 1'b1) begin n_bad++; $display("FAIL min_half: got n=%0d tick=%b expected n=1 tick=1", n, tick[0]); end
        n_cmp++; if (div_pending[0] !== 1'b0) begin n_bad++; $display("FAIL min_pending_clear: got %b expected 0", div_pending[0]); end
    endtask

    task automatic test_async_reset;
        int n;
        if (out_clk[1] !== 1'b1) wait_toggle(1, n);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (out_clk !== 2'b00) begin n_bad++; $display("FAIL async_out_clk: got %b expected 00", out_clk); end
        n_cmp++; if (tick !== 2'b00) begin n_bad++; $display("FAIL async_tick: got %b expected 00", tick); end
        n_cmp++; if (div_pending !== 2'b00) begin n_bad++; $display("FAIL async_pending: got %b expected 00", div_pending); end
        enable = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        enable = 2'b01;
        wait_toggle(0, n);
        n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL async_div_default: got %0d expected 17", n); end
    endtask

`ifdef CLK_DIV_PHASE_ALIGN_EN
    task automatic test_align;
        int n;
        logic bad;
        enable = 2'b00;
        repeat (40) @(negedge clk);
        div_in = {CNT_W'(5), CNT_W'(5)};
        div_load = 2'b11;
        @(negedge clk);
        div_load = 2'b00;
        enable = 2'b01;
        repeat (3) @(negedge clk);
        enable = 2'b11;
        repeat (7) @(negedge clk);
        align = 1'b1;
        @(negedge clk);
        align = 1'b0;
        n_cmp++; if (out_clk !== 2'b00 || tick !== 2'b00) begin n_bad++; $display("FAIL align_force: got out=%b tick=%b expected 00/00", out_clk, tick); end
        wait_toggle(0, n);
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL align_first_half: got %0d expected 5", n); end
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_clk[0] !== out_clk[1]) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL align_locked: got skew=%b expected 0", bad); end
    endtask
`endif

    initial begin
        test_reset();
        test_default();
        test_reload();
        test_collision();
        test_disable();
        test_zero_min();
        test_async_reset();
`ifdef CLK_DIV_PHASE_ALIGN_EN
        test_align();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel programmable clock divider.
- Each channel derives a divided clock from `clk`, with a runtime-loadable half-period divisor and a per-channel enable.
- Divisor changes take effect glitch-free at half-period boundaries.
- Sits beside the fabric clock to generate slow strobes and clocks for test logic (e.g. sequence generators, LED and UART pacing).

Parameters:
- NUM_CH, 2: number of independent divider channels (1..8).
- CNT_W, 20: width of the divisor and half-period counter.
- DEFAULT_DIV, 16: divisor loaded into every channel at reset (must be >= 1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  NUM_CH  per-channel run enable.
- div_in  in  NUM_CH*CNT_W  new divisor per channel; channel k occupies bits [k*CNT_W +: CNT_W].
- div_load  in  NUM_CH  one-cycle strobe; captures the channel's div_in slice into its shadow register.
- div_pending  out  NUM_CH  shadow divisor captured but not yet applied.
- out_clk  out  NUM_CH  divided clock; period = 2*div_act cycles, 50% duty.
- tick  out  NUM_CH  one-cycle pulse, asserted in the same cycle as each out_clk toggle.

Behaviour:
- Reset (asynchronous assert, synchronous release), per channel:
  - cycle = 0, out_clk = 0, tick = 0
  - div_act = DEFAULT_DIV, shadow = DEFAULT_DIV, div_pending = 0
  - state = IDLE
- States per channel: IDLE, RUN, DRAIN.
- IDLE:
  - cycle is held at 0 and out_clk = 0.
  - enable=1 -> RUN. Counting starts next cycle from 0; the first toggle occurs div_act cycles after entry.
- RUN:
  - cycle increments each clk.
  - At cycle == div_act-1: cycle <= 0, out_clk toggles, tick = 1 for that cycle.
  - If div_pending is set at that boundary: div_act <= shadow and div_pending <= 0, effective for the next half-period.
  - enable=0 with out_clk=0 -> IDLE immediately (cycle <= 0).
  - enable=0 with out_clk=1 -> DRAIN.
- DRAIN:
  - Keeps counting until the falling toggle completes the high phase, then -> IDLE. No runt high pulse is ever produced.
  - enable re-asserted in DRAIN -> back to RUN with no disturbance to the count.
- Divisor load:
  - div_load=1 -> shadow <= div_in slice and div_pending <= 1 on the next edge.
  - A new load while pending overwrites shadow; last write wins.
  - Load in IDLE: div_act <= value directly and div_pending stays 0.
  - Load in the same cycle as a boundary: the old shadow (if pending) applies at this boundary; the new value stays pending until the next boundary.
- Divisor value 0 is clamped to 1, so the minimum out_clk period is 2 clk.
- Channels are fully independent; there is no cross-channel interaction.
- out_clk and tick are registered outputs. There is no combinational path from any input to any output.

Optional Feature:
- Macro: CLK_DIV_PHASE_ALIGN_EN.
- Defined:
  - Adds input port `align` (1 bit).
  - A one-cycle pulse forces every channel's cycle to 0 and out_clk to 0 on the next edge; tick = 0; pending divisors are applied immediately.
  - Channels with equal divisors are thereafter phase-locked.
  - align has priority over a simultaneous boundary and over div_load; a concurrent div_load is still captured as pending.
- Undefined: the port does not exist and channels free-run from their individual enable times.

Decomposition:
- Package clk_div_pkg:
  - Constants CLK_DIV_CNT_W_DEF = 20 and CLK_DIV_MIN = 1.
  - Channel state enum typedef (IDLE, RUN, DRAIN).
  - Clamp function (0 -> 1).
- Sub-module clk_div_chan: one channel (counter, shadow register, FSM), instantiated NUM_CH times in a generate loop.
- Top level: port slicing and, when the macro is defined, align fan-out.

Test Plan:
- Reset default: NUM_CH=2, release reset, enable=2'b11 -> both out_clk period 32 clk, 16 high; tick every 16 cycles.
- Live reload: ch0 running div 16, div_load with div_in=4 mid-half-period -> div_pending=1 until the next toggle; from the following half-period onward the period is 8; div_pending then clears.
- Glitch-free disable: deassert ch0 enable 3 cycles after a rising toggle (div 16) -> out_clk stays high 13 more cycles, falls, stays 0 in IDLE; ch1 unaffected.
- Zero and minimum divisor: load 0 in IDLE, enable -> out_clk toggles every cycle (period 2); load 1 -> same.
- Boundary collision: div_load=1 with div_in=8 exactly on a toggle cycle while shadow=4 pending -> next half-period is 4, the one after is 8.
- Asynchronous reset mid-run: assert reset between edges while out_clk=1 -> out_clk=0 and tick=0 immediately; div_act returns to 16. With CLK_DIV_PHASE_ALIGN_EN: an align pulse with ch0 div 5 and ch1 div 5 at different phases -> identical out_clk waveforms afterwards.
